// File: rtl/md_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl_pkg
//   Shared definitions for the multiply/divide issue controller:
//   MD-class op codes, controller state encodings and op classification
//   helpers. No ports.
// ---------------------------------------------------------------------------
package md_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READ  = 2'd3
  } md_state_e;

  localparam int WD_CNT_W = 5;

  // MFHI/MFLO only read HI/LO; they never occupy the MDU.
  function automatic logic is_mf(md_op_e op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // MTHI/MTLO write HI/LO directly and need no Busy wait.
  function automatic logic is_mt(md_op_e op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   Pipeline-side initiator for the multiply/divide unit. Accepts one MD-class
//   instruction at a time from E, drives the MDU Start/MDOp/MDWrite/MDsel and
//   operand interface, waits on MDU Busy, returns MFHI/MFLO results and stalls
//   E while the MDU is occupied. A watchdog bounds the Busy wait.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  MD instruction present in E
//   req_op     MD_* op code
//   req_rs     forwarded rs value
//   req_rt     forwarded rt value
//   flush      kill the instruction offered in E this cycle
//   req_ready  controller can accept a request this cycle
//   stall      hold E and earlier stages
//   md_start   MDU Start (calculation ops, ISSUE only)
//   md_op      MDU MDOp (ISSUE only, else 0)
//   md_write   MDU MDWrite (MTHI/MTLO, ISSUE only)
//   md_sel     MDU MDsel: 0 = LO, 1 = HI (READ only)
//   md1, md2   MDU operands (ISSUE only, else 0)
//   md_busy    MDU Busy
//   md_rdata   MDU MDout
//   rd_valid   one-cycle pulse: MF result valid
//   rd_data    MF result
//   wd_err     sticky watchdog error
// ---------------------------------------------------------------------------
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int WD_LIMIT = 31,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_rs,
  input  logic [DW-1:0] req_rt,
  input  logic          flush,
  output logic          req_ready,
  output logic          stall,
  output logic          md_start,
  output logic [2:0]    md_op,
  output logic          md_write,
  output logic          md_sel,
  output logic [DW-1:0] md1,
  output logic [DW-1:0] md2,
  input  logic          md_busy,
  input  logic [DW-1:0] md_rdata,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          wd_err
);

  localparam logic [WD_CNT_W-1:0] WD_LIMIT_C = WD_CNT_W'(WD_LIMIT);

  md_state_e             r_state;
  md_state_e             w_state_nxt;
  md_op_e                r_op;
  logic [DW-1:0]         r_rs;
  logic [DW-1:0]         r_rt;
  logic [WD_CNT_W-1:0]   r_wd_cnt;
  logic                  r_wd_err;
  logic                  r_rd_valid;
  logic [DW-1:0]         r_rd_data;
  logic                  w_accept;
  logic                  w_wd_fire;
  md_op_e                w_req_op;

  assign w_req_op = md_op_e'(req_op);

  // Handshake outputs are gated by reset so that every output reads 0 while
  // the controller is held in reset.
  assign req_ready = reset && (r_state == ST_IDLE) && !md_busy;
  assign stall     = reset && req_valid && !req_ready && !flush;
  assign w_accept  = req_valid && req_ready && !flush;

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign wd_err    = r_wd_err;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    md_start    = 1'b0;
    md_write    = 1'b0;
    md_op       = '0;
    md_sel      = 1'b0;
    md1         = '0;
    md2         = '0;
    w_wd_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = is_mf(w_req_op) ? ST_READ : ST_ISSUE;
      end
      ST_ISSUE: begin
        md_op = r_op;
        md1   = r_rs;
        md2   = r_rt;
        if (is_mt(r_op)) begin
          md_write    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          md_start    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Busy is already high on entry (raised at the Start edge); the first
        // low cycle ends the wait, otherwise the watchdog may cut it short.
        if (!md_busy) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wd_cnt == WD_LIMIT_C) begin
          w_wd_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        md_sel      = (r_op == MD_MFHI);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values. Every register here is reset,
  // including the request payload, so outputs are clean straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= MD_MULT;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wd_cnt   <= '0;
      r_wd_err   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= w_req_op;
        r_rs <= req_rs;
        r_rt <= req_rt;
      end
      // ISSUE always precedes WAIT, so clearing here clears on WAIT entry.
      if (r_state == ST_ISSUE) begin
        r_wd_cnt <= '0;
      end else if ((r_state == ST_WAIT) && md_busy && !w_wd_fire) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_wd_fire) r_wd_err <= 1'b1;
      // A flush during READ only drops the pulse; the data is still captured.
      r_rd_valid <= (r_state == ST_READ) && !flush;
      if (r_state == ST_READ) r_rd_data <= md_rdata;
    end
  end

endmodule
